// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: hex digits or 4-character opcode mnemonics.
// Latency: seg/dp/an are registered and follow the prescaler/scan index by one clk.
// No backpressure: load is a single-cycle strobe that is always accepted unless rst is high.
// Optional feature: define SEG7_LZ_BLANK_EN to blank leading-zero digits in hex mode.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    mode,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [3:0]              opcode,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PSC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Character codes used by the mnemonic table.
  typedef enum logic [3:0] {
    CH_SP, CH_A, CH_B, CH_C, CH_D, CH_H, CH_I, CH_L,
    CH_N,  CH_O, CH_R, CH_S, CH_U, CH_V, CH_X, CH_Z
  } char_t;

  // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble (A, b, C, d, E, F forms).
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Active-high pattern for a mnemonic character; B/D/R/N use the lowercase forms.
  function automatic logic [6:0] char_seg(input char_t c);
    logic [6:0] s;
    case (c)
      CH_A:    s = 7'h77;
      CH_B:    s = 7'h7C;
      CH_C:    s = 7'h39;
      CH_D:    s = 7'h5E;
      CH_H:    s = 7'h76;
      CH_I:    s = 7'h06;
      CH_L:    s = 7'h38;
      CH_N:    s = 7'h54;
      CH_O:    s = 7'h3F;
      CH_R:    s = 7'h50;
      CH_S:    s = 7'h6D;
      CH_U:    s = 7'h3E;
      CH_V:    s = 7'h3E;
      CH_X:    s = 7'h76;
      CH_Z:    s = 7'h5B;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Four characters per opcode, leftmost in the top nibble, space-padded on the right.
  function automatic logic [15:0] mnemonic(input logic [3:0] op);
    logic [15:0] m;
    case (op)
      4'h0: m = {CH_L, CH_D, CH_A, CH_SP};
      4'h1: m = {CH_L, CH_D, CH_B, CH_SP};
      4'h2: m = {CH_L, CH_D, CH_O, CH_SP};
      4'h3: m = {CH_L, CH_D, CH_S, CH_A};
      4'h4: m = {CH_L, CH_D, CH_S, CH_B};
      4'h5: m = {CH_L, CH_S, CH_H, CH_SP};
      4'h6: m = {CH_R, CH_S, CH_H, CH_SP};
      4'h7: m = {CH_C, CH_L, CH_R, CH_SP};
      4'h8: m = {CH_S, CH_N, CH_Z, CH_A};
      4'h9: m = {CH_S, CH_N, CH_Z, CH_S};
      4'hA: m = {CH_A, CH_D, CH_D, CH_SP};
      4'hB: m = {CH_S, CH_U, CH_B, CH_SP};
      4'hC: m = {CH_A, CH_N, CH_D, CH_SP};
      4'hD: m = {CH_O, CH_R, CH_SP, CH_SP};
      4'hE: m = {CH_X, CH_O, CH_R, CH_SP};
      default: m = {CH_I, CH_N, CH_V, CH_SP};
    endcase
    return m;
  endfunction

  // Shadow copy of the display request; only these feed the glyph logic.
  logic                    sh_mode;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [3:0]              sh_opcode;
  logic [NUM_DIGITS-1:0]   sh_dp;

  // Scan state.
  logic [PW-1:0] psc;
  logic [IW-1:0] idx;

  // Glyph frozen at the start of the current slot so a mid-slot load cannot tear it.
  logic [6:0] slot_seg;
  logic       slot_dp;

  // Glyph for the current index, computed from the shadow registers.
  logic [6:0]  cur_seg;
  logic        cur_dp;
  logic [3:0]  cur_nib;
  logic [15:0] cur_mn;
  int          idx_i;
  int          pos;

  // Capture the display request on load; reset wins over a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode   <= 1'b0;
      sh_value  <= '0;
      sh_opcode <= '0;
      sh_dp     <= '0;
    end else if (load) begin
      sh_mode   <= mode;
      sh_value  <= value;
      sh_opcode <= opcode;
      sh_dp     <= dp_in;
    end
  end

  // Prescaler wraps every REFRESH_DIV cycles and steps the scan index on its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
      idx <= '0;
    end else if (psc == PSC_LAST) begin
      psc <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      psc <= psc + 1'b1;
    end
  end

  // Decode the shadow contents for the digit currently being scanned.
  always_comb begin
    cur_seg = 7'h7F;
    cur_dp  = 1'b1;
    idx_i   = int'(idx);
    pos     = 0;
    cur_nib = sh_value[4*idx_i +: 4];
    cur_mn  = mnemonic(sh_opcode);
    if (sh_mode) begin
      // Mnemonic occupies the four leftmost digits; anything to the right stays blank.
      if (idx_i >= NUM_DIGITS - 4) begin
        pos     = NUM_DIGITS - 1 - idx_i;
        cur_seg = ~char_seg(char_t'(cur_mn[4*(3-pos) +: 4]));
      end
    end else begin
      cur_seg = ~hex_seg(cur_nib);
      cur_dp  = ~sh_dp[idx];
`ifdef SEG7_LZ_BLANK_EN
      // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows.
      if (idx_i != 0 && (sh_value >> (4*idx_i)) == '0) begin
        cur_seg = 7'h7F;
      end
`endif
    end
  end

  // Guard cycle at prescaler 0 blanks all anodes and freezes the slot glyph; later cycles light it.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_seg <= 7'h7F;
      slot_dp  <= 1'b1;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      an       <= '1;
    end else if (psc == '0) begin
      slot_seg <= cur_seg;
      slot_dp  <= cur_dp;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      an       <= '1;
    end else begin
      seg      <= slot_seg;
      dp       <= slot_dp;
      an       <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4 clk per slot).
// Table vectors plus hand sequences, then random loads/resets against a slot-level model.
module tb_seg7_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          mode;
  logic [15:0]   value;
  logic [3:0]    opcode;
  logic [3:0]    dp_in;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .value(value),
    .opcode(opcode), .dp_in(dp_in), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: cycle count since reset, shadow request, frozen slot glyph.
  int          n;
  logic        m_mode;
  logic [15:0] m_val;
  logic [3:0]  m_op;
  logic [3:0]  m_dpi;
  logic [6:0]  m_slot_seg;
  logic        m_slot_dp;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  int          exp_digit;

  string hexs = "0123456789AbCdEF";
  string mn [16] = '{"LDA", "LDB", "LDO", "LDSA", "LDSB", "LSH", "RSH", "CLR",
                     "SNZA", "SNZS", "ADD", "SUB", "AND", "OR", "XOR", "INV"};

  function automatic logic [6:0] ch_on(input byte c);
    case (c)
      "0", "O":      return 7'h3F;
      "1", "I":      return 7'h06;
      "2", "Z":      return 7'h5B;
      "3":           return 7'h4F;
      "4":           return 7'h66;
      "5", "S":      return 7'h6D;
      "6":           return 7'h7D;
      "7":           return 7'h07;
      "8":           return 7'h7F;
      "9":           return 7'h6F;
      "A":           return 7'h77;
      "b", "B":      return 7'h7C;
      "C":           return 7'h39;
      "d", "D":      return 7'h5E;
      "E":           return 7'h79;
      "F":           return 7'h71;
      "H", "X":      return 7'h76;
      "L":           return 7'h38;
      "N":           return 7'h54;
      "R":           return 7'h50;
      "U", "V":      return 7'h3E;
      default:       return 7'h00;
    endcase
  endfunction

  // What digit d should show given the model's shadow request.
  task automatic glyph(input int d, output logic [6:0] sg, output logic dpo);
    string s;
    byte   c;
    int    p;
    logic [3:0] nib;
    bit    lead;
    if (m_mode) begin
      dpo = 1'b1;
      sg  = 7'h7F;
      if (d >= ND - 4) begin
        s  = mn[m_op];
        p  = ND - 1 - d;
        c  = (p < s.len()) ? s[p] : " ";
        sg = ~ch_on(c);
      end
    end else begin
      nib = 4'((m_val >> (4*d)) & 16'hF);
      sg  = ~ch_on(hexs[nib]);
      dpo = ~m_dpi[d];
`ifdef SEG7_LZ_BLANK_EN
      lead = (d != 0);
      for (int k = d; k < ND; k++) if (((m_val >> (4*k)) & 16'hF) != 0) lead = 0;
      if (lead) sg = 7'h7F;
`else
      lead = 0;
`endif
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, n);
    end
  endtask

  // One clock edge: advance the model with the inputs present at that edge, then compare.
  task automatic step();
    int phase;
    int dig;
    @(posedge clk);
    #1;
    if (rst) begin
      n = 0; m_mode = 0; m_val = 0; m_op = 0; m_dpi = 0;
      m_slot_seg = 7'h7F; m_slot_dp = 1'b1;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_digit = -1;
    end else begin
      phase = n % DIV;
      dig   = (n / DIV) % ND;
      if (phase == 0) begin
        glyph(dig, m_slot_seg, m_slot_dp);
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_digit = -1;
      end else begin
        exp_seg = m_slot_seg; exp_dp = m_slot_dp;
        exp_an = ~(4'b0001 << dig); exp_digit = dig;
      end
      n++;
      if (load) begin
        m_mode = mode; m_val = value; m_op = opcode; m_dpi = dp_in;
      end
    end
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("dp",  32'(dp),  32'(exp_dp));
    chk("an",  32'(an),  32'(exp_an));
  endtask

  typedef struct packed {
    logic        mode;
    logic [15:0] value;
    logic [3:0]  opcode;
    logic [3:0]  dpi;
    logic [27:0] sg;    // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpo;
  } vec_t;

  vec_t tbl [5];
  bit   found;

  initial begin
    tbl[0] = '{1'b0, 16'h1A2F, 4'h0, 4'h0, {7'h79, 7'h08, 7'h24, 7'h0E}, 4'hF};
    tbl[1] = '{1'b1, 16'h0000, 4'hD, 4'h0, {7'h40, 7'h2F, 7'h7F, 7'h7F}, 4'hF};
`ifdef SEG7_LZ_BLANK_EN
    tbl[2] = '{1'b0, 16'h0050, 4'h0, 4'h0, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
`else
    tbl[2] = '{1'b0, 16'h0050, 4'h0, 4'h0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
`endif
    tbl[3] = '{1'b0, 16'h89AB, 4'h0, 4'h5, {7'h00, 7'h10, 7'h08, 7'h03}, 4'hA};
    tbl[4] = '{1'b1, 16'h1234, 4'h3, 4'h0, {7'h47, 7'h21, 7'h12, 7'h08}, 4'hF};

    n = 0; exp_digit = -1;
    rst = 1'b1; load = 1'b0; mode = 1'b0; value = '0; opcode = '0; dp_in = '0;

    // Reset held three cycles: outputs fully blank throughout.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold_an", 32'(an), 32'hF);
    end
    rst = 1'b0;
    step();
    chk("first_guard_an", 32'(an), 32'hF);
    step();
    chk("first_digit_an", 32'(an), 32'hE);

    // Load mid-slot on digit 1: that slot keeps '0', the digit 2 slot shows '2'.
    found = 0;
    for (int i = 0; i < 4*DIV*ND && !found; i++) begin
      step();
      if (exp_digit == 1) found = 1;
    end
    chk("midslot_reach_digit1", 32'(found), 32'd1);
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    chk("midslot_keeps_old", 32'(seg), 32'h40);
    found = 0;
    for (int i = 0; i < 3*DIV && !found; i++) begin
      step();
      if (exp_digit == 2) begin
        found = 1;
        chk("next_slot_new", 32'(seg), 32'h24);
      end
    end
    chk("midslot_reach_digit2", 32'(found), 32'd1);

    // Reset coincident with load: no capture, every digit shows '0'.
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF; mode = 1'b0;
    step();
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < DIV*ND + 1; i++) begin
      step();
      if (exp_digit >= 0) begin
        chk("rst_load_seg", 32'(seg), 32'h40);
        chk("rst_load_dp",  32'(dp),  32'h1);
      end
    end

    // Table vectors: load, wait for a fresh scan, compare every lit cycle.
    for (int t = 0; t < 5; t++) begin
      mode = tbl[t].mode; value = tbl[t].value; opcode = tbl[t].opcode; dp_in = tbl[t].dpi;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < DIV*ND && (n % (DIV*ND)) != 0; i++) step();
      for (int i = 0; i < DIV*ND + 1; i++) begin
        step();
        if (exp_digit >= 0) begin
          chk($sformatf("tbl%0d_seg_d%0d", t, exp_digit), 32'(seg), 32'(tbl[t].sg[7*exp_digit +: 7]));
          chk($sformatf("tbl%0d_dp_d%0d", t, exp_digit), 32'(dp), 32'(tbl[t].dpo[exp_digit]));
        end
      end
    end

    // Random loads and occasional resets against the model.
    for (int i = 0; i < 2000; i++) begin
      rst    = ($urandom_range(0, 149) == 0);
      load   = ($urandom_range(0, 7) == 0);
      mode   = 1'($urandom);
      value  = 16'($urandom);
      opcode = 4'($urandom);
      dp_in  = 4'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal range 4..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot (minimum 4).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  single-cycle strobe capturing mode/value/opcode/dp_in.
REQ-006 SHALL have port mode  input  1  0 = hex mode, 1 = opcode-mnemonic mode.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit.
REQ-008 SHALL have port opcode  input  4  opcode shown as mnemonic in opcode mode.
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  per-digit decimal point request, active high.
REQ-010 SHALL have port seg  output  7  {g,f,e,d,c,b,a}, active low.
REQ-011 SHALL have port dp  output  1  decimal point, active low.
REQ-012 SHALL have port an  output  NUM_DIGITS  digit enables, active low, at most one low at any time.

Function
REQ-013 SHALL capture mode, value, opcode, dp_in into shadow registers on the clk edge where load=1; the display uses only shadow contents.
REQ-014 SHALL display a captured value starting with the first digit slot that begins after the capture edge; a slot already in progress SHALL keep its old content.
REQ-015 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; the scan index SHALL advance when the prescaler is at REFRESH_DIV-1.
REQ-016 SHALL advance the scan index 0,1,...,NUM_DIGITS-1, then wrap to 0.
REQ-017 SHALL drive an all-high (blanking guard) while the prescaler is 0, to prevent ghosting.
REQ-018 SHALL drive an[idx]=0 for prescaler values 1..REFRESH_DIV-1, with seg and dp valid and stable for that digit throughout.
REQ-019 SHALL register seg, dp and an; the outputs reflect state one cycle after the prescaler/index update.
REQ-020 SHALL, in hex mode, decode nibble idx into glyphs 0-9 and A-F (A, b, C, d, E, F forms).
REQ-021 SHALL, in opcode mode, show the 4-character mnemonic on digits NUM_DIGITS-1 (left) down to NUM_DIGITS-4, with all other digits blank: 0 LDA, 1 LDB, 2 LDO, 3 LDSA, 4 LDSB, 5 LSH, 6 RSH, 7 CLR, 8 SNZA, 9 SNZS, A ADD, B SUB, C AND, D OR, E XOR, F INV; mnemonics shorter than 4 characters SHALL be left-aligned and space-padded.
REQ-022 SHALL encode blank as seg=7'h7F.
REQ-023 SHALL drive dp=~dp_shadow[idx] in hex mode and dp=1 in opcode mode.
REQ-024 SHALL give reset priority when rst and load coincide; no capture occurs.

Reset
REQ-025 SHALL, on rst, set the prescaler to 0, idx to 0, shadow mode=0, value=0, opcode=0, dp=0, seg=7'h7F, dp=1, and an all ones, effective at the next edge.
REQ-026 SHALL abandon a scan on rst mid-scan with no partial slot, and restart from digit 0 with the guard cycle after rst deasserts.

Configuration
REQ-027 SHALL implement leading-zero blanking when macro SEG7_LZ_BLANK_EN is defined: in hex mode, zero nibbles above the most-significant nonzero nibble are blank, dp is still honoured, and digit 0 is always shown.
REQ-028 SHALL show every nibble, including leading zeros, when SEG7_LZ_BLANK_EN is undefined.

Verification
REQ-029 SHALL verify: rst held 3 cycles -> seg=7F, an=F, dp=1 throughout; after release, the first an=E appears at prescaler=1.
REQ-030 SHALL verify: REFRESH_DIV=4, load value=16'h1A2F, mode=0 -> digit order F,2,A,1 on an=E,D,B,7, each slot 1 guard cycle + 3 lit cycles.
REQ-031 SHALL verify: load mode=1, opcode=4'hD -> digits left to right O, r, blank, blank; dp=1 on all slots.
REQ-032 SHALL verify: value=16'h0050 with SEG7_LZ_BLANK_EN -> blank, blank, 5, 0; without the macro -> 0, 0, 5, 0.
REQ-033 SHALL verify: load 16'h1234 mid-slot on digit 1 -> that slot keeps old content; digit 2 slot shows 2; rst coincident with load -> shadow stays 0.
